// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, one-outstanding imem request channel, epoch-tagged
// response matching, one-entry park buffer and the IF/ID register. Optional FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall_f,
  input  logic        Stall_d,
  input  logic        Flush_d,
  input  logic        PCSrc_e,
  input  logic [31:0] PCTarget_e,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] Instr_d,
  output logic [31:0] PC_d,
  output logic [31:0] PCPlus4_d,
  output logic        Valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
`endif
);

  // state  | meaning
  // S_REQ  | no request outstanding
  // S_WAIT | one request outstanding
  // S_HOLD | response parked in the fetch buffer while Stall_d is high
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc_f;
  logic [31:0] w_pc_nxt;
  logic        r_epoch;
  logic        w_epoch_nxt;
  logic        r_req_epoch;
  logic [31:0] r_buf_data;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pcplus4_d;
  logic        r_valid_d;

  logic [31:0] w_pc_plus4;
  logic        w_rsp_match;
  logic        w_req_valid;
  logic [31:0] w_addr;
  logic        w_deliver;
  logic [31:0] w_deliver_data;
  logic        w_park;
  logic        w_discard;
  logic        w_handshake;

  assign w_pc_plus4  = r_pc_f + 32'd4;
  assign w_rsp_match = imem_rsp_valid && (r_req_epoch == r_epoch);

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc_f;
    w_epoch_nxt    = r_epoch;
    w_req_valid    = 1'b0;
    w_addr         = r_pc_f;
    w_deliver      = 1'b0;
    w_deliver_data = r_buf_data;
    w_park         = 1'b0;
    w_discard      = 1'b0;

    case (r_state)
      S_REQ: begin
        w_req_valid = !Stall_f;
        if (!Stall_f && imem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (!w_rsp_match) begin
            w_discard   = 1'b1;
            w_state_nxt = S_REQ;
          end else if (!Stall_d) begin
            w_deliver      = 1'b1;
            w_deliver_data = imem_rsp_data;
            w_pc_nxt       = w_pc_plus4;
            if (!Stall_f) begin
              // chain the next fetch in the same cycle to sustain one instruction per cycle
              w_req_valid = 1'b1;
              w_addr      = w_pc_plus4;
              w_state_nxt = imem_req_ready ? S_WAIT : S_REQ;
            end else begin
              w_state_nxt = S_REQ;
            end
          end else begin
            w_park      = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!Stall_d) begin
          w_deliver      = 1'b1;
          w_deliver_data = r_buf_data;
          w_pc_nxt       = w_pc_plus4;
          w_state_nxt    = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase

    // redirect wins over everything; a request still in flight is tracked but will mismatch
    if (PCSrc_e) begin
      w_req_valid = 1'b0;
      w_deliver   = 1'b0;
      w_park      = 1'b0;
      w_pc_nxt    = PCTarget_e;
      w_epoch_nxt = ~r_epoch;
      w_state_nxt = (r_state == S_WAIT && !imem_rsp_valid) ? S_WAIT : S_REQ;
    end
  end

  assign imem_req_valid = w_req_valid & rst_n;
  assign imem_addr      = w_addr;
  assign w_handshake    = imem_req_valid & imem_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_REQ;
      r_pc_f      <= RESET_PC;
      r_epoch     <= 1'b0;
      r_req_epoch <= 1'b0;
      r_buf_data  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc_f  <= w_pc_nxt;
      r_epoch <= w_epoch_nxt;
      if (w_handshake) r_req_epoch <= r_epoch;
      if (w_park)      r_buf_data  <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_d   <= NOP_INSTR;
      r_pc_d      <= 32'h0;
      r_pcplus4_d <= 32'h0;
      r_valid_d   <= 1'b0;
    end else if (Flush_d) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (w_deliver) begin
      r_instr_d   <= w_deliver_data;
      r_pc_d      <= r_pc_f;
      r_pcplus4_d <= w_pc_plus4;
      r_valid_d   <= 1'b1;
    end else if (!Stall_d) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end
  end

  assign Instr_d   = r_instr_d;
  assign PC_d      = r_pc_d;
  assign PCPlus4_d = r_pcplus4_d;
  assign Valid_d   = r_valid_d;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_discarded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched   <= 32'h0;
      r_perf_discarded <= 32'h0;
    end else begin
      if (w_deliver && r_perf_fetched != 32'hFFFF_FFFF)
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_discard && r_perf_discarded != 32'hFFFF_FFFF)
        r_perf_discarded <= r_perf_discarded + 32'd1;
    end
  end

  assign perf_fetched   = r_perf_fetched;
  assign perf_discarded = r_perf_discarded;
`endif

endmodule
